// File: rtl/truth_table_sweeper_pkg.sv
// Shared types and sizes for the 4-input truth-table sweep-and-check stage.
package tt_pkg;

   localparam int NUM_VECTORS = 16;
   localparam int IDX_W       = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DRIVE  = 2'd1,
      FINISH = 2'd2
   } state_t;

endpackage

// File: rtl/truth_table_sweeper_hold_counter.sv
// Dwell counter for one input combination; o_last marks the cycle whose
// following edge samples the DUT output.
module hold_counter #(
   parameter int HOLD_CYCLES = 4
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_clr,
   input  logic i_en,
   output logic o_last
);

   localparam logic [7:0] LAST = 8'(HOLD_CYCLES - 1);

   logic [7:0] r_cnt;
   logic       w_last;

   assign w_last = (r_cnt == LAST);
   assign o_last = w_last;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt <= 8'd0;
      end else if (i_clr) begin
         r_cnt <= 8'd0;
      end else if (i_en) begin
         r_cnt <= w_last ? 8'd0 : r_cnt + 8'd1;
      end
   end

endmodule

// File: rtl/truth_table_sweeper.sv
// Steps {x,y,w,z} through 0..15, captures f per combination and compares the
// captured truth table with a table latched at start.
module truth_table_sweeper
   import tt_pkg::*;
#(
   parameter int HOLD_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] expected_tt,
   input  logic        f,
   output logic        x,
   output logic        y,
   output logic        w,
   output logic        z,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [15:0] truth_table,
   output logic [4:0]  mismatch_count,
   output logic [3:0]  first_mismatch
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VECTORS - 1);

   state_t           r_state;
   logic [IDX_W-1:0] r_idx;
   logic [IDX_W-1:0] r_vec;
   logic [15:0]      r_exp;
   logic [15:0]      r_tt;
   logic [4:0]       r_cnt;
   logic [3:0]       r_first;
   logic             r_busy;
   logic             r_done;
   logic             r_pass;

   logic             w_accept;
   logic             w_last;
   logic             w_sample;
   logic             w_miss;
   logic [4:0]       w_cnt_nxt;

   assign w_accept  = (r_state == IDLE) && start;
   assign w_sample  = (r_state == DRIVE) && w_last;
   assign w_miss    = f ^ r_exp[r_idx];
   assign w_cnt_nxt = r_cnt + {4'd0, w_miss};

   hold_counter #(
      .HOLD_CYCLES(HOLD_CYCLES)
   ) u_hold (
      .i_clk (clk),
      .i_rst (rst),
      .i_clr (w_accept),
      .i_en  (r_state == DRIVE),
      .o_last(w_last)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_idx   <= '0;
         r_vec   <= '0;
         r_exp   <= '0;
         r_tt    <= '0;
         r_cnt   <= '0;
         r_first <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_pass  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_state <= DRIVE;
                  r_idx   <= '0;
                  r_vec   <= '0;
                  r_exp   <= expected_tt;
                  r_tt    <= '0;
                  r_cnt   <= '0;
                  r_first <= '0;
                  r_pass  <= 1'b0;
                  r_busy  <= 1'b1;
               end
            end
            DRIVE: begin
               if (w_sample) begin
                  r_tt[r_idx] <= f;
                  r_cnt       <= w_cnt_nxt;
                  // Count still zero means this is the first miss of the sweep.
                  if (w_miss && (r_cnt == 5'd0)) begin
                     r_first <= r_idx;
                  end
                  if (r_idx == LAST_IDX) begin
                     r_state <= FINISH;
                     r_done  <= 1'b1;
                     r_pass  <= (w_cnt_nxt == 5'd0);
                  end else begin
                     r_idx <= r_idx + 1'b1;
                     r_vec <= r_idx + 1'b1;
                  end
               end
            end
            FINISH: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
               r_vec   <= '0;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign {x, y, w, z}   = r_vec;
   assign busy           = r_busy;
   assign done           = r_done;
   assign pass           = r_pass;
   assign truth_table    = r_tt;
   assign mismatch_count = r_cnt;
   assign first_mismatch = r_first;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboard bench: two sweepers (HOLD_CYCLES 4 and 1) around behavioural f models.
module tb_truth_table_sweeper;

   localparam int HC0 = 4;
   localparam int HC1 = 1;

   typedef struct {
      logic [15:0] tt;
      logic        pass;
      logic [4:0]  cnt;
      logic [3:0]  first;
      int          e0;
   } exp_t;

   logic        clk = 1'b0;
   logic [1:0]  rst;
   logic [1:0]  start;
   logic [1:0]  f;
   logic [15:0] exp_tt [2];
   logic [15:0] rnd    [2];
   int          mode   [2];

   wire  [1:0]  x, y, w, z, busy, done, pass;
   wire  [15:0] tt   [2];
   wire  [4:0]  cnt  [2];
   wire  [3:0]  fm   [2];

   exp_t q0[$];
   exp_t q1[$];
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   truth_table_sweeper #(.HOLD_CYCLES(HC0)) u_dut0 (
      .clk(clk), .rst(rst[0]), .start(start[0]), .expected_tt(exp_tt[0]), .f(f[0]),
      .x(x[0]), .y(y[0]), .w(w[0]), .z(z[0]), .busy(busy[0]), .done(done[0]),
      .pass(pass[0]), .truth_table(tt[0]), .mismatch_count(cnt[0]), .first_mismatch(fm[0])
   );

   truth_table_sweeper #(.HOLD_CYCLES(HC1)) u_dut1 (
      .clk(clk), .rst(rst[1]), .start(start[1]), .expected_tt(exp_tt[1]), .f(f[1]),
      .x(x[1]), .y(y[1]), .w(w[1]), .z(z[1]), .busy(busy[1]), .done(done[1]),
      .pass(pass[1]), .truth_table(tt[1]), .mismatch_count(cnt[1]), .first_mismatch(fm[1])
   );

   function automatic int hc(int d);
      return (d == 0) ? HC0 : HC1;
   endfunction

   // Circuits under test: 0 parity, 1 x&y, 2 tied low, 3 ~z, other: lookup table r.
   function automatic logic f_of(int m, logic [15:0] r, logic [3:0] v);
      case (m)
         0:       return ^v;
         1:       return v[3] & v[2];
         2:       return 1'b0;
         3:       return ~v[0];
         default: return r[v];
      endcase
   endfunction

   always_comb begin
      f = '0;
      for (int d = 0; d < 2; d++) f[d] = f_of(mode[d], rnd[d], {x[d], y[d], w[d], z[d]});
   end

   task automatic chk(string name, logic [31:0] act, logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic exp_t model(int m, logic [15:0] r, logic [15:0] e, int e0);
      exp_t        ent;
      logic [15:0] dif;
      for (int i = 0; i < 16; i++) ent.tt[i] = f_of(m, r, 4'(i));
      dif       = ent.tt ^ e;
      ent.pass  = (dif == 16'd0);
      ent.cnt   = 5'($countones(dif));
      ent.first = 4'd0;
      for (int i = 15; i >= 0; i--) if (dif[i]) ent.first = 4'(i);
      ent.e0    = e0;
      return ent;
   endfunction

   task automatic push(int d, exp_t ent);
      if (d == 0) q0.push_back(ent);
      else        q1.push_back(ent);
   endtask

   task automatic sweep(int d, int m, logic [15:0] r, logic [15:0] e);
      @(negedge clk);
      mode[d] = m; rnd[d] = r; exp_tt[d] = e; start[d] = 1'b1;
      push(d, model(m, r, e, cyc + 1));
      @(negedge clk);
      start[d] = 1'b0;
   endtask

   task automatic wait_idle(int d);
      int n = 0;
      int sz;
      sz = (d == 0) ? q0.size() : q1.size();
      while (sz > 0 && n < 2000) begin
         @(negedge clk);
         n++;
         sz = (d == 0) ? q0.size() : q1.size();
      end
      chk("drain_timeout", sz, 0);
   endtask

   task automatic rst_chk(int d);
      chk("rst_ctrl", {x[d], y[d], w[d], z[d], busy[d], done[d], pass[d]}, 0);
      chk("rst_tt", tt[d], 0);
      chk("rst_cnt", cnt[d], 0);
      chk("rst_first", fm[d], 0);
   endtask

   always @(negedge clk) begin : mon
      exp_t me;
      int   sz;
      int   rel;
      for (int d = 0; d < 2; d++) begin
         sz = (d == 0) ? q0.size() : q1.size();
         if (!rst[d]) begin
            if (sz > 0) begin
               me  = (d == 0) ? q0[0] : q1[0];
               rel = cyc - me.e0;
               if (rel >= 0 && rel < 16 * hc(d))
                  chk("vec", {x[d], y[d], w[d], z[d]}, rel / hc(d));
               if (rel >= 0 && rel <= 16 * hc(d))
                  chk("busy", busy[d], 1);
            end
            if (done[d]) begin
               if (sz == 0) begin
                  chk("spurious_done", done[d], 0);
               end else begin
                  if (d == 0) me = q0.pop_front();
                  else        me = q1.pop_front();
                  chk("done_time", cyc, me.e0 + 16 * hc(d));
                  chk("truth_table", tt[d], me.tt);
                  chk("pass", pass[d], me.pass);
                  chk("mismatch_count", cnt[d], me.cnt);
                  chk("first_mismatch", fm[d], me.first);
               end
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] r, e;
      rst = 2'b11; start = 2'b00;
      for (int d = 0; d < 2; d++) begin exp_tt[d] = '0; rnd[d] = '0; mode[d] = 0; end
      repeat (3) @(negedge clk);
      rst_chk(0); rst_chk(1);
      rst = 2'b00;

      sweep(0, 0, 16'h0, 16'h6996); wait_idle(0);
      sweep(0, 1, 16'h0, 16'hF001); wait_idle(0);
      sweep(0, 2, 16'h0, 16'hFFFF); wait_idle(0);
      sweep(1, 3, 16'h0, 16'h5555); wait_idle(1);

      // Reset while idx=7: no done may follow (queue left empty).
      @(negedge clk);
      mode[0] = 0; exp_tt[0] = 16'h6996; start[0] = 1'b1;
      @(negedge clk);
      start[0] = 1'b0;
      repeat (7 * HC0) @(negedge clk);
      chk("pre_rst_vec", {x[0], y[0], w[0], z[0]}, 7);
      rst[0] = 1'b1;
      #1 rst_chk(0);
      @(negedge clk);
      rst[0] = 1'b0;
      repeat (5) @(negedge clk);
      sweep(0, 0, 16'h0, 16'h6996); wait_idle(0);

      // Reset and start together: reset wins.
      @(negedge clk);
      rst[0] = 1'b1; start[0] = 1'b1;
      @(negedge clk);
      rst[0] = 1'b0; start[0] = 1'b0;
      @(negedge clk);
      chk("rst_start_busy", busy[0], 0);

      // Start pulse and new expected table at idx=5: ignored.
      r = 16'($urandom); e = r ^ 16'h0410;
      sweep(0, 4, r, e);
      repeat (5 * HC0) @(negedge clk);
      chk("busy_vec", {x[0], y[0], w[0], z[0]}, 5);
      start[0] = 1'b1; exp_tt[0] = ~e;
      @(negedge clk);
      start[0] = 1'b0;
      wait_idle(0);
      repeat (20) @(negedge clk);

      // Start held high: back-to-back sweeps two edges apart.
      @(negedge clk);
      r = 16'($urandom);
      mode[1] = 4; rnd[1] = r; exp_tt[1] = r; start[1] = 1'b1;
      push(1, model(4, r, r, cyc + 1));
      push(1, model(4, r, r, cyc + 1 + 16 * HC1 + 2));
      repeat (16 * HC1 + 3) @(negedge clk);
      start[1] = 1'b0;
      wait_idle(1);

      for (int i = 0; i < 10; i++) begin
         r = 16'($urandom);
         e = (i % 3 == 0) ? r : r ^ (16'($urandom) & 16'($urandom));
         sweep(i % 2, 4, r, e);
         wait_idle(i % 2);
      end

      repeat (10) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Sequential stimulus-and-capture stage for 4-input combinational blocks such as circuit2.
- Drives the DUT inputs x, y, w, z through all 16 combinations in ascending order, with x as MSB and z as LSB.
- Samples the DUT output f for each combination, builds a 16-bit truth table and compares it with an expected table.
- Provides the synthesizable sweep-and-check that sits around the combinational circuit under test.

Parameters:
- HOLD_CYCLES, 4: clock cycles each input combination is held. Legal range 1..255. f is sampled on the last cycle of each hold.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset; asynchronous, active-high.
- start  input  1  begin a sweep. Honoured only in IDLE.
- expected_tt  input  16  expected truth table; bit i is the expected f for {x,y,w,z}=i. Latched on an accepted start.
- f  input  1  DUT output being checked.
- x  output  1  DUT input, bit 3 of the combination index.
- y  output  1  DUT input, bit 2 of the combination index.
- w  output  1  DUT input, bit 1 of the combination index.
- z  output  1  DUT input, bit 0 of the combination index.
- busy  output  1  high in DRIVE and FINISH.
- done  output  1  one-cycle pulse when a sweep completes.
- pass  output  1  captured table equals expected_tt. Valid from done until the next accepted start.
- truth_table  output  16  captured table; bit i = f sampled at index i.
- mismatch_count  output  5  number of mismatching indices, 0..16.
- first_mismatch  output  4  lowest mismatching index. 0 when pass=1.

Behaviour:
- Asynchronous reset, active-high. All outputs are registered and reset to the following values:
  - state = IDLE;
  - x, y, w, z = 0;
  - busy, done, pass = 0;
  - truth_table = 0;
  - mismatch_count = 0;
  - first_mismatch = 0;
  - internal idx = 0, hold_cnt = 0, exp_q = 0.
- State machine has three states: IDLE, DRIVE, FINISH.
- IDLE:
  - x, y, w, z held at 0.
  - Result outputs keep their last values.
  - On start=1 at a clock edge (edge E0):
    - go to DRIVE;
    - set idx=0 and hold_cnt=0;
    - set exp_q=expected_tt;
    - clear truth_table, mismatch_count, first_mismatch and pass;
    - set busy=1.
- DRIVE:
  - {x,y,w,z} = idx, registered, so it changes on the same edge idx changes.
  - hold_cnt increments every cycle.
  - When hold_cnt == HOLD_CYCLES-1, the next edge is the sample edge. On it:
    - truth_table[idx] <= f;
    - if f != exp_q[idx], increment mismatch_count;
    - if that mismatch is the first of the sweep, set first_mismatch <= idx;
    - clear hold_cnt;
    - if idx==15, go to FINISH; otherwise increment idx.
- FINISH (exactly one cycle):
  - done=1.
  - pass = (mismatch_count==0).
  - {x,y,w,z} returns to 0 on the next edge, together with the transition to IDLE.
  - busy drops on the same edge.
- Timing:
  - Sample edges are E0 + k·HOLD_CYCLES for k=1..16.
  - done is high in the cycle after edge E0 + 16·HOLD_CYCLES.
  - Total busy duration is 16·HOLD_CYCLES+1 cycles.
- Boundary conditions:
  - start while busy (DRIVE or FINISH): ignored, no restart.
  - start held high continuously: a new sweep begins on the first IDLE cycle edge after FINISH.
  - expected_tt changes mid-sweep: no effect, since exp_q is used.
  - idx never wraps. FINISH is reached after exactly 16 samples.
  - mismatch_count saturates naturally at 16; a 5-bit width is required.
  - HOLD_CYCLES=1: every DRIVE cycle is a sample edge.
  - rst asserted mid-sweep: immediate return to reset values, with no done pulse.
  - rst asserted in the same cycle as start: rst wins.

Decomposition:
- Shared package tt_pkg holds:
  - state enum {IDLE, DRIVE, FINISH};
  - constant NUM_VECTORS=16;
  - constant IDX_W=4.
- One natural sub-module: hold_counter (parameterized HOLD_CYCLES, inputs clr/en, output last). It generates the sample strobe.
- Compare/accumulate logic and the FSM stay in the top module.

Test Plan:
- Parity truth table:
  - Stimulus: f = x^y^w^z, expected_tt=16'h6996, HOLD_CYCLES=4, start pulse.
  - Required: x,y,w,z step 0000..1111 every 4 cycles; done one cycle after edge E0+64; truth_table=16'h6996, pass=1, mismatch_count=0, first_mismatch=0.
- Single mismatch:
  - Stimulus: f = x&y, expected_tt=16'hF001.
  - Required: truth_table=16'hF000, pass=0, mismatch_count=1, first_mismatch=0.
- All wrong:
  - Stimulus: f tied 0, expected_tt=16'hFFFF.
  - Required: mismatch_count=16, first_mismatch=0, pass=0.
- Minimum hold:
  - Stimulus: HOLD_CYCLES=1, f = ~z, expected_tt=16'h5555.
  - Required: done one cycle after edge E0+16, pass=1.
- Reset mid-sweep:
  - Stimulus: assert rst while idx=7.
  - Required: all outputs immediately at reset values, no done pulse; a new start then runs a full clean sweep.
- Start while busy:
  - Stimulus: pulse start at idx=5, and change expected_tt.
  - Required: sweep continues unchanged, results use the originally latched table, exactly one done pulse.
